fifo_rd_serializer: RTL and testbench
=====================================

Name: fifo_rd_serializer

Overview:
- Reader/drain end for the team's synchronous FIFO raw read port (r_req / r_data / r_stall).
- Pops COL_BIT_WIDTH-bit words and emits them as BEATS = COL_BIT_WIDTH/BEAT_WIDTH narrow beats on a ready/valid output stream, LSB beat first, with a last-beat marker.
- Sits between a FIFO and a narrow consumer, e.g. a byte-wide UART TX or debug port.

Parameters:
- COL_BIT_WIDTH, 32, FIFO word width; must equal the FIFO's COL_BIT_WIDTH.
- BEAT_WIDTH, 8, output beat width; COL_BIT_WIDTH must be an integer multiple of BEAT_WIDTH with BEATS >= 2 (elaboration-time check, fatal on violation).
- BEATS (localparam), COL_BIT_WIDTH/BEAT_WIDTH, beats per word.
- CNT_W (localparam), $clog2(BEATS), beat counter width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fifo_r_req  out  1  pop request to FIFO; combinational from state and fifo_r_stall
- fifo_r_data  in  COL_BIT_WIDTH  FIFO read data; valid only in the cycle fifo_r_req=1 and fifo_r_stall=0
- fifo_r_stall  in  1  FIFO empty
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  BEAT_WIDTH  current beat
- out_last  out  1  current beat is beat BEATS-1 of the word
- busy  out  1  a word is held (state != IDLE)

Behaviour:
- Reset (async assert, sync-to-clk deassert by system): state=IDLE, shift reg=0, beat_cnt=0, out_valid=0, out_data=0, out_last=0, busy=0, fifo_r_req=0. Reset mid-word discards the remaining beats; FIFO pointers are not touched.
- FIFO read data is combinational and zero unless popped, so fifo_r_data is captured in the same cycle fifo_r_req=1 and fifo_r_stall=0. Never pop without capturing.
- State IDLE:
  - fifo_r_req = !fifo_r_stall.
  - On pop: shreg<=fifo_r_data, beat_cnt<=0, state<=SHIFT.
  - Latency: word visible at edge N -> out_valid=1 in cycle N+1.
- State SHIFT:
  - out_valid=1, out_data=shreg[BEAT_WIDTH-1:0], out_last=(beat_cnt==BEATS-1).
  - Handshake = out_valid & out_ready. On handshake with !out_last: shreg>>=BEAT_WIDTH, beat_cnt++.
  - Handshake on last beat:
    - If !fifo_r_stall: fifo_r_req=1 in that cycle, reload shreg, beat_cnt<=0, stay in SHIFT (zero-bubble back-to-back words).
    - Else: state<=IDLE.
- fifo_r_req=0 in SHIFT except on the last-beat handshake.
- No handshake: out_data and out_last hold and out_valid stays 1. Valid never drops without a handshake, and data never changes under valid.
- out_data/out_last are driven from registers (shreg, beat_cnt); no combinational path from out_ready to out_data.
- beat_cnt wraps only via explicit reload to 0; no modular overflow.
- busy = (state != IDLE).

Optional Feature:
- Macro: FIFO_RD_SER_PREFETCH_EN
- Defined: adds one COL_BIT_WIDTH prefetch register plus pf_valid flag, reset to 0/0.
  - In SHIFT with pf_valid=0 and !fifo_r_stall: fifo_r_req=1 and pf<=fifo_r_data, pf_valid<=1 (frees the FIFO slot early).
  - On last-beat handshake with pf_valid=1: shreg<=pf, pf_valid<=0, no FIFO pop that cycle.
  - On last-beat handshake with pf_valid=0: fall back to the direct-reload rule.
  - At most one pop per cycle.
  - busy = (state!=IDLE) | pf_valid.
- Undefined: no prefetch register; behaviour exactly as in Behaviour above.

Test Plan:
- Reset with FIFO empty (r_stall=1), hold 10 cycles -> fifo_r_req=0, out_valid=0, out_data=0, busy=0 throughout.
- Push 0xA1B2C3D4, out_ready=1 -> one pop; beats D4,C3,B2,A1 on 4 consecutive cycles starting 1 cycle after the pop; out_last only on A1; then IDLE.
- Push 0x11223344 and 0x55667788, out_ready=1 -> 8 beats in 8 consecutive cycles (44,33,22,11,88,77,66,55); second pop coincides with the 11 handshake.
- Push 0xDEADBEEF, out_ready toggles 1,0,0,1,0,1,1 -> out_data holds EF/BE/AD/DE stable while out_ready=0; no extra pops; exactly 4 handshakes.
- Push 0xCAFEF00D, assert reset_n=0 after 2 beats (0D,F0) -> outputs return to 0 immediately; after release with FIFO empty, no further beats.
- FIFO_RD_SER_PREFETCH_EN, push 3 words, out_ready=0 -> second pop occurs 1 cycle after the first; FIFO holds 1 word; then out_ready=1 gives 12 gap-free beats.

Source files
------------

// File: rtl/fifo_rd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_serializer
// Purpose  : Drains a synchronous FIFO through its raw read port and emits
//            each COL_BIT_WIDTH-bit word as BEATS narrow beats on a
//            ready/valid stream, least-significant beat first, with a
//            last-beat marker.
// Ports    :
//   clk          in   clock, all state on rising edge
//   reset_n      in   asynchronous active-low reset
//   fifo_r_req   out  pop request to the FIFO (combinational)
//   fifo_r_data  in   FIFO read data, valid while popping
//   fifo_r_stall in   FIFO empty
//   out_valid    out  beat valid
//   out_ready    in   consumer accepts beat
//   out_data     out  current beat
//   out_last     out  current beat is the final beat of the word
//   busy         out  a word is held (or prefetched)
// Options  : define FIFO_RD_SER_PREFETCH_EN to add a one-word prefetch
//            register that frees the FIFO slot while the current word is
//            still being shifted out.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_serializer #(
    parameter int COL_BIT_WIDTH = 32,
    parameter int BEAT_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     fifo_r_req,
    input  logic [COL_BIT_WIDTH-1:0] fifo_r_data,
    input  logic                     fifo_r_stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BEAT_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int BEATS = COL_BIT_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] c_LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if ((COL_BIT_WIDTH % BEAT_WIDTH) != 0 || BEATS < 2) begin : g_param_check
            $fatal(1, "fifo_rd_serializer: COL_BIT_WIDTH must be a multiple of BEAT_WIDTH with at least 2 beats");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                   r_state;
    logic [COL_BIT_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]         r_beat_cnt;

    logic w_last;
    logic w_hs;
    logic w_last_hs;
    logic w_pop;

    assign w_last    = (r_state == S_SHIFT) && (r_beat_cnt == c_LAST_BEAT);
    assign w_hs      = (r_state == S_SHIFT) && out_ready;
    assign w_last_hs = w_hs && w_last;

`ifdef FIFO_RD_SER_PREFETCH_EN
    logic [COL_BIT_WIDTH-1:0] r_pf;
    logic                     r_pf_valid;

    // In SHIFT an empty prefetch slot is always refilled when the FIFO has
    // data. On a last-beat handshake that same pop feeds the shift register
    // directly instead, so there is never more than one pop per cycle.
    assign w_pop = (r_state == S_IDLE) ? !fifo_r_stall : (!r_pf_valid && !fifo_r_stall);
    assign busy  = (r_state != S_IDLE) || r_pf_valid;
`else
    assign w_pop = (r_state == S_IDLE) ? !fifo_r_stall : (w_last_hs && !fifo_r_stall);
    assign busy  = (r_state != S_IDLE);
`endif

    // Gated by reset so no word is ever popped while it cannot be captured.
    assign fifo_r_req = w_pop && reset_n;

    assign out_valid = (r_state == S_SHIFT);
    assign out_data  = r_shreg[BEAT_WIDTH-1:0];
    assign out_last  = w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_beat_cnt <= '0;
`ifdef FIFO_RD_SER_PREFETCH_EN
            r_pf       <= '0;
            r_pf_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shreg    <= fifo_r_data;
                        r_beat_cnt <= '0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_hs && !w_last) begin
                        r_shreg    <= r_shreg >> BEAT_WIDTH;
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end else if (w_last_hs) begin
                        r_beat_cnt <= '0;
`ifdef FIFO_RD_SER_PREFETCH_EN
                        if (r_pf_valid) begin
                            r_shreg    <= r_pf;
                            r_pf_valid <= 1'b0;
                        end else
`endif
                        if (!fifo_r_stall) begin
                            // Zero-bubble reload of the next word.
                            r_shreg <= fifo_r_data;
                        end else begin
                            r_shreg <= '0;
                            r_state <= S_IDLE;
                        end
                    end
`ifdef FIFO_RD_SER_PREFETCH_EN
                    if (w_pop && !w_last_hs) begin
                        r_pf       <= fifo_r_data;
                        r_pf_valid <= 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_serializer
// Purpose  : Self-checking bench for fifo_rd_serializer. A behavioural FIFO
//            feeds the DUT; every pushed word is expanded into its expected
//            beat list, and every accepted beat is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_r_req;
    logic [31:0] fifo_r_data;
    logic        fifo_r_stall;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;

    always #5 clk = ~clk;

    // Behavioural FIFO: combinational read data, zero unless popped.
    logic [31:0] fmem [0:255];
    int          fwr = 0;
    int          frd = 0;

    assign fifo_r_stall = (fwr == frd);
    assign fifo_r_data  = (fifo_r_req && !fifo_r_stall) ? fmem[frd[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (fifo_r_req && !fifo_r_stall) frd <= frd + 1;
    end

    fifo_rd_serializer #(
        .COL_BIT_WIDTH (32),
        .BEAT_WIDTH    (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fifo_r_req   (fifo_r_req),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_stall (fifo_r_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
    );

    int         checks = 0;
    int         passes = 0;
    int         fails  = 0;
    int         cyc    = 0;
    logic [8:0] exp_q[$];      // {last, data} per expected beat
    int         hs_log[$];
    int         pop_log[$];
    logic       hold_prev = 1'b0;
    logic [8:0] prev_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fmem[fwr[7:0]] = w;
        fwr = fwr + 1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({(i == 3), w[8*i +: 8]});
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        if (fifo_r_req && !fifo_r_stall) pop_log.push_back(cyc);
`ifdef FIFO_RD_SER_PREFETCH_EN
        if (out_valid) chk("busy_when_valid", busy, 1'b1);
`else
        chk("busy", busy, out_valid);
        if (reset_n)
            chk("req_rule", fifo_r_req,
                out_valid ? (out_ready && out_last && !fifo_r_stall) : !fifo_r_stall);
`endif
        if (hold_prev) chk("hold", {out_valid, out_last, out_data}, {1'b1, prev_beat});
        if (out_valid && out_ready) begin
            chk("beat_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat", {out_last, out_data}, e);
            end
            hs_log.push_back(cyc);
        end
        hold_prev = out_valid && !out_ready && reset_n;
        prev_beat = {out_last, out_data};
    endtask

    task automatic tick();
        #1;
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        hs_log.delete();
        pop_log.delete();
    endtask

    initial begin
        int         c0;
        int         c1;
        logic [6:0] pat;

        reset_n   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset with the FIFO empty: everything quiet for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("reset_outs", {fifo_r_req, out_valid, out_last, busy, out_data}, 12'h0);
            @(negedge clk);
            cyc++;
        end
        reset_n = 1'b1;
        ticks(2);

        // Single word, consumer always ready.
        clear_logs();
        out_ready = 1'b1;
        push(32'hA1B2C3D4);
        c0 = cyc;
        ticks(6);
        chk("w1_pops", pop_log.size(), 1);
        chk("w1_pop_cyc", pop_log[0], c0);
        chk("w1_hs", hs_log.size(), 4);
        chk("w1_first_hs", hs_log[0], c0 + 1);
        chk("w1_last_hs", hs_log[3], c0 + 4);
        #1;
        chk("w1_idle", {out_valid, busy}, 2'b00);
        chk("w1_drained", exp_q.size(), 0);

        // Two back-to-back words: eight gap-free beats.
        clear_logs();
        push(32'h11223344);
        push(32'h55667788);
        c0 = cyc;
        ticks(10);
        chk("w2_pops", pop_log.size(), 2);
        chk("w2_pop0", pop_log[0], c0);
`ifdef FIFO_RD_SER_PREFETCH_EN
        chk("w2_pop1", pop_log[1], c0 + 1);
`else
        chk("w2_pop1", pop_log[1], hs_log[3]);
`endif
        chk("w2_hs", hs_log.size(), 8);
        chk("w2_first_hs", hs_log[0], c0 + 1);
        chk("w2_last_hs", hs_log[7], c0 + 8);

        // Back-pressure: ready pattern 1,0,0,1,0,1,1 after the word appears.
        clear_logs();
        out_ready = 1'b0;
        push(32'hDEADBEEF);
        c0 = cyc;
        tick();
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            tick();
        end
        out_ready = 1'b1;
        ticks(2);
        chk("bp_pops", pop_log.size(), 1);
        chk("bp_hs", hs_log.size(), 4);
        chk("bp_last_hs", hs_log[3], c0 + 7);
        chk("bp_drained", exp_q.size(), 0);

        // Reset in the middle of a word.
        clear_logs();
        push(32'hCAFEF00D);
        ticks(3);
        chk("mid_hs", hs_log.size(), 2);
        reset_n = 1'b0;
        #1;
        chk("async_rst", {fifo_r_req, out_valid, out_last, busy, out_data}, 12'h0);
        exp_q.delete();
        hold_prev = 1'b0;
        @(negedge clk);
        cyc++;
        ticks(2);
        reset_n = 1'b1;
        clear_logs();
        ticks(5);
        chk("post_rst_hs", hs_log.size(), 0);
        chk("post_rst_pops", pop_log.size(), 0);

        // Three words queued while the consumer stalls, then released.
        clear_logs();
        out_ready = 1'b0;
        push(32'h03020100);
        push(32'h07060504);
        push(32'h0B0A0908);
        c0 = cyc;
        ticks(4);
`ifdef FIFO_RD_SER_PREFETCH_EN
        chk("pf_pops", pop_log.size(), 2);
        chk("pf_pop1", pop_log[1], c0 + 1);
        chk("pf_fifo_lvl", fwr - frd, 1);
`else
        chk("pf_pops", pop_log.size(), 1);
        chk("pf_fifo_lvl", fwr - frd, 2);
`endif
        out_ready = 1'b1;
        c1 = cyc;
        ticks(16);
        chk("pf_hs", hs_log.size(), 12);
        chk("pf_first_hs", hs_log[0], c1);
        chk("pf_last_hs", hs_log[11], c1 + 11);
        chk("pf_total_pops", pop_log.size(), 3);

        // Random traffic against the beat-list model.
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && (fwr - frd) < 6) push($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_fifo_empty", fwr - frd, 0);
        #1;
        chk("rand_idle", out_valid, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
